// File: rtl/vend_ctrl.sv
// Coin-accumulating vend sequencer: credit, one-cycle vend, unit-per-cycle change/refund, idle timeout.
// Latency: coin/cancel sampled at edge N is reflected in state and outputs in cycle N+1.
// No backpressure: coins offered while busy (VEND/CHANGE) are dropped and flagged on Err.
module vend_ctrl #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          D_in,
    input  logic                Cancel,
    output logic                Vend_out,
    output logic                Change_out,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Busy,
    output logic                Err
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C      = CREDIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CREDIT_W-1:0]   r_credit;
    logic [CREDIT_W-1:0]   w_credit_nxt;
    logic [TIMER_W-1:0]    r_timer;
    logic [TIMER_W-1:0]    w_timer_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [CREDIT_W-1:0]   w_coin_val;
    logic [CREDIT_W-1:0]   w_sum;
    logic                  w_coin;
    logic                  w_accepting;

    // Coin decode: 01 -> 1, 10 -> 2; the illegal code 11 carries no value.
    assign w_coin      = (D_in == 2'b01) || (D_in == 2'b10);
    assign w_coin_val  = w_coin ? CREDIT_W'(D_in) : '0;
    assign w_sum       = r_credit + w_coin_val;
    assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_COLLECT);

    // State, credit, timer and error registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
            r_timer  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_timer  <= w_timer_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state, credit and timer decisions; cancel outranks vend so a coin arriving with cancel is refunded.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_timer_nxt  = '0;
        w_err_nxt    = (D_in == 2'b11) || ((D_in != 2'b00) && !w_accepting);

        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (w_coin) begin
                    if (Cancel) begin
                        w_state_nxt  = ST_CHANGE;
                        w_credit_nxt = w_sum;
                    end else if (w_sum >= PRICE_C) begin
                        w_state_nxt  = ST_VEND;
                        w_credit_nxt = w_sum - PRICE_C;
                    end else begin
                        w_state_nxt  = ST_COLLECT;
                        w_credit_nxt = w_sum;
                    end
                end else if (r_credit != '0) begin
                    // Only reachable in COLLECT: IDLE always holds zero credit.
                    if (Cancel || (r_timer == TIMER_LAST)) begin
                        w_state_nxt = ST_CHANGE;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                    end
                end
            end
            ST_VEND: begin
                w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                w_credit_nxt = r_credit - ONE_C;
                if (r_credit == ONE_C) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    // Moore-decoded outputs from the registered state.
    always_comb begin
        Vend_out   = (r_state == ST_VEND);
        Change_out = (r_state == ST_CHANGE);
        Busy       = (r_state == ST_VEND) || (r_state == ST_CHANGE);
        Credit     = r_credit;
        Err        = r_err;
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed test-plan steps then random coins, all against a phase-queue model.
// Latency: every edge is followed by a #1 sample of all outputs against the model.
// No backpressure; coins while busy are expected to raise Err only.
module tb_vend_ctrl;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;
    localparam int TIMEOUT  = 15;

    logic                Clk;
    logic                Reset;
    logic [1:0]          D_in;
    logic                Cancel;
    logic                Vend_out;
    logic                Change_out;
    logic [CREDIT_W-1:0] Credit;
    logic                Busy;
    logic                Err;

    int total = 0;
    int bad   = 0;

    vend_ctrl #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .D_in       (D_in),
        .Cancel     (Cancel),
        .Vend_out   (Vend_out),
        .Change_out (Change_out),
        .Credit     (Credit),
        .Busy       (Busy),
        .Err        (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: a queue of upcoming output cycles (vend/change/credit shown) plus idle-credit bookkeeping.
    typedef struct {
        bit v;
        bit c;
        int cr;
    } phase_t;

    phase_t m_q[$];
    int     m_credit = 0;
    int     m_idle   = 0;
    bit     m_err    = 0;

    task automatic push_refund(input int n);
        phase_t p;
        for (int k = n; k >= 1; k--) begin
            p.v = 0; p.c = 1; p.cr = k;
            m_q.push_back(p);
        end
        m_credit = 0;
        m_idle   = 0;
    endtask

    task automatic model_edge(input logic [1:0] d, input bit c, input bit rst_n);
        int     val;
        int     sum;
        phase_t p;
        if (!rst_n) begin
            m_q.delete();
            m_credit = 0;
            m_idle   = 0;
            m_err    = 0;
            return;
        end
        m_err = (d == 2'b11) || ((d != 2'b00) && (m_q.size() > 0));
        if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            return;
        end
        val = (d == 2'b01) ? 1 : (d == 2'b10) ? 2 : 0;
        if (val > 0) begin
            sum = m_credit + val;
            if (c) begin
                push_refund(sum);
            end else if (sum >= PRICE) begin
                p.v = 1; p.c = 0; p.cr = sum - PRICE;
                m_q.push_back(p);
                push_refund(sum - PRICE);
            end else begin
                m_credit = sum;
                m_idle   = 0;
            end
        end else if (m_credit > 0) begin
            if (c) begin
                push_refund(m_credit);
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) push_refund(m_credit);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int ev, ec, ecr;
        ev  = (m_q.size() > 0) ? int'(m_q[0].v) : 0;
        ec  = (m_q.size() > 0) ? int'(m_q[0].c) : 0;
        ecr = (m_q.size() > 0) ? m_q[0].cr : m_credit;
        chk({tag, ".vend"},   32'(Vend_out),   32'(ev));
        chk({tag, ".change"}, 32'(Change_out), 32'(ec));
        chk({tag, ".credit"}, 32'(Credit),     32'(ecr));
        chk({tag, ".busy"},   32'(Busy),       32'(m_q.size() > 0));
        chk({tag, ".err"},    32'(Err),        32'(m_err));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, sample outputs 1 time unit later.
    task automatic cyc(input string tag, input logic [1:0] d, input bit c, input bit rst_n);
        Reset  = rst_n;
        D_in   = d;
        Cancel = c;
        @(posedge Clk);
        model_edge(d, c, rst_n);
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset  = 1'b0;
        D_in   = 2'b00;
        Cancel = 1'b0;
        #2;

        // 1: reset overrides coin and cancel
        cyc("rst0", 2'b10, 1, 0);
        cyc("rst1", 2'b10, 1, 0);
        chk("rst.credit_const", 32'(Credit), 32'd0);
        chk("rst.vend_const",   32'(Vend_out), 32'd0);
        cyc("t1.coin", 2'b01, 0, 1);
        chk("t1.credit_const", 32'(Credit), 32'd1);
        cyc("t1.cancel", 2'b00, 1, 1);
        cyc("t1.drain", 2'b00, 0, 1);

        // 2: three single coins -> exact vend, no change
        cyc("t2.c1", 2'b01, 0, 1);
        cyc("t2.c2", 2'b01, 0, 1);
        cyc("t2.c3", 2'b01, 0, 1);
        chk("t2.vend_const", 32'(Vend_out), 32'd1);
        chk("t2.credit_const", 32'(Credit), 32'd0);
        cyc("t2.after", 2'b00, 0, 1);
        chk("t2.nochange_const", 32'(Change_out), 32'd0);

        // 3: two doubles -> vend then one change unit
        cyc("t3.c1", 2'b10, 0, 1);
        cyc("t3.c2", 2'b10, 0, 1);
        chk("t3.vend_credit_const", 32'(Credit), 32'd1);
        cyc("t3.chg", 2'b00, 0, 1);
        chk("t3.change_const", 32'(Change_out), 32'd1);
        cyc("t3.idle", 2'b00, 0, 1);

        // 4: coin with cancel is refunded, not vended
        cyc("t4.c1", 2'b10, 0, 1);
        cyc("t4.cc", 2'b01, 1, 1);
        chk("t4.credit3_const", 32'(Credit), 32'd3);
        chk("t4.novend_const", 32'(Vend_out), 32'd0);
        for (int i = 0; i < 4; i++) cyc("t4.drain", 2'b00, 0, 1);

        // 5: timeout fires exactly TIMEOUT idle edges after the last coin
        cyc("t5.coin", 2'b01, 0, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc("t5.wait", 2'b00, 0, 1);
        chk("t5.early_const", 32'(Change_out), 32'd0);
        cyc("t5.fire", 2'b00, 0, 1);
        chk("t5.fire_const", 32'(Change_out), 32'd1);
        cyc("t5.end", 2'b00, 0, 1);
        chk("t5.single_const", 32'(Change_out), 32'd0);
        // coin at idle edge 10 restarts the timer
        cyc("t5r.coin", 2'b01, 0, 1);
        for (int i = 0; i < 9; i++) cyc("t5r.wait", 2'b00, 0, 1);
        cyc("t5r.coin2", 2'b01, 0, 1);
        for (int i = 0; i < TIMEOUT + 4; i++) cyc("t5r.run", 2'b00, 0, 1);

        // 6: illegal coin, coin during change, reset mid-change
        cyc("t6.ill", 2'b11, 0, 1);
        chk("t6.err_const", 32'(Err), 32'd1);
        cyc("t6.ill2", 2'b11, 0, 1);
        cyc("t6.c1", 2'b10, 0, 1);
        cyc("t6.cc", 2'b10, 1, 1);
        cyc("t6.busycoin", 2'b01, 0, 1);
        cyc("t6.errchk", 2'b00, 0, 1);
        cyc("t6.rst", 2'b00, 0, 0);
        chk("t6.rst_credit_const", 32'(Credit), 32'd0);
        for (int i = 0; i < 3; i++) cyc("t6.post", 2'b00, 0, 1);

        // Random: dense traffic, then sparse traffic so timeouts occur
        for (int i = 0; i < 600; i++) begin
            logic [1:0] d;
            d = 2'($urandom_range(0, 3));
            cyc("rnd", d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
        end
        for (int i = 0; i < 800; i++) begin
            logic [1:0] d;
            d = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc("rnd_sparse", d, ($urandom_range(0, 59) == 0), ($urandom_range(0, 199) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Sequencing controller for the vending datapath. It accepts coins on the shared 2-bit coin code, accumulates credit and fires a one-cycle vend when the price is reached. It returns change one unit per cycle and refunds on cancel or inactivity timeout. It instantiates alongside the Mealy/Moore vend detectors, consuming the same `D_in` coin encoding, and adds credit, change and error handling.

## Interface
- `PRICE`, default 3: item price in coin units; legal range 1 .. 2^CREDIT_W-3.
- `CREDIT_W`, default 4: width of the credit register.
- `TIMEOUT`, default 15: number of consecutive idle cycles in COLLECT before an automatic refund; must be ≥1.

- `Clk` in 1: single clock; all logic on the rising edge.
- `Reset` in 1: synchronous, active-low reset (0 = reset, sampled on the rising edge of `Clk`).
- `D_in` in 2: coin code. 00 = none, 01 = 1 unit, 10 = 2 units, 11 = illegal.
- `Cancel` in 1: refund request, level-sampled each cycle.
- `Vend_out` out 1: dispense pulse, one cycle per item.
- `Change_out` out 1: one unit of change or refund per high cycle.
- `Credit` out CREDIT_W: current credit register.
- `Busy` out 1: high in VEND and CHANGE.
- `Err` out 1: one-cycle pulse for an illegal or rejected coin.

## Operation
- States: IDLE, COLLECT, VEND, CHANGE. All outputs are registered or Moore-decoded; none depend combinationally on inputs.
- Reset (`Reset`=0 at an edge): state = IDLE, `Credit` = 0, timer = 0, and all outputs = 0. Reset overrides every other input and applies in every state, including mid-CHANGE; any pending refund is discarded.
- `Vend_out` = (state==VEND). `Change_out` = (state==CHANGE). `Busy` = VEND | CHANGE.
- A coin is accepted only in IDLE or COLLECT.
  - `D_in`=11 in any state: `Err`=1 next cycle; credit unchanged.
  - `D_in`≠00 in VEND or CHANGE: ignored; `Err`=1 next cycle.
- On an accepted coin, sum = `Credit` + coin value.
  - `Cancel`=1 in the same cycle: go to CHANGE with `Credit`=sum. Cancel beats vend, and the coin is refunded rather than lost.
  - Otherwise, if sum ≥ PRICE: go to VEND with `Credit` = sum − PRICE.
  - Otherwise: go to COLLECT with `Credit` = sum, and timer cleared.
- `Cancel` with no coin:
  - In COLLECT: go to CHANGE.
  - In IDLE with `Credit`=0: no effect.
  - In VEND or CHANGE: ignored.
- COLLECT with no coin and no cancel: timer increments. When the timer reaches TIMEOUT, go to CHANGE.
- VEND lasts exactly one cycle. Next state is CHANGE if `Credit`>0, else IDLE.
- CHANGE: `Credit` decrements by 1 each cycle. The cycle in which `Credit` transitions 1→0 is the last `Change_out` cycle; the next state is IDLE.
  - Number of `Change_out` cycles always equals the credit at entry.
  - CHANGE is never entered with `Credit`=0.
- Width rule: with PRICE ≤ 2^CREDIT_W−3, sum never exceeds 2^CREDIT_W−1, so no saturation logic is needed.
- Timer width: $clog2(TIMEOUT+1).

## Timing
- Coin sampled at edge N: `Credit` updated and visible in cycle N+1.
  - If the price is reached, `Vend_out`=1 in cycle N+1 only.
  - First `Change_out` is in cycle N+2.
- Cancel sampled at edge N: first `Change_out` in cycle N+1.
- Timeout: with the last coin at edge N, the TIMEOUT edges N+1..N+TIMEOUT carry no input activity. CHANGE starts in cycle N+TIMEOUT+1.
- `Err` is high for exactly one cycle per offending sample. Back-to-back offending samples give back-to-back pulses.
- A new coin is accepted at the edge following the last CHANGE or VEND cycle (state is then IDLE).

## Test plan
Defaults (PRICE=3, TIMEOUT=15) throughout.
1. Hold `Reset`=0 for 2 edges with `D_in`=10 and `Cancel`=1 → all outputs 0 and `Credit`=0. Release reset, then drive `D_in`=01 → `Credit`=1 next cycle.
2. Drive `D_in` = 01, 01, 01 on consecutive edges → `Credit` reads 1, 2, then `Vend_out`=1 for one cycle with `Credit`=0. No `Change_out` pulse. Returns to IDLE.
3. Drive `D_in` = 10, 10 → `Credit`=2, then `Vend_out`=1 with `Credit`=1. Next cycle `Change_out`=1 with `Credit`→0. Then IDLE.
4. Drive `D_in`=10, then `D_in`=01 together with `Cancel`=1 → no vend; 3 consecutive `Change_out` pulses; `Credit` goes 3→0.
5. Drive `D_in`=01, then 00 for 15 edges → exactly 1 `Change_out` pulse, starting 16 cycles after the coin edge. A coin at idle edge 10 restarts the timer instead.
6. `D_in`=11 in IDLE → `Err` pulse, `Credit`=0. `D_in`=01 during CHANGE → `Err` pulse and refund count unchanged. Assert `Reset`=0 mid-CHANGE → outputs 0 and `Credit`=0 the next cycle; no further `Change_out`.
